// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the word bus between the CPU memory-access stage and
// its responders: responder FSM state encoding, read/write encoding of rw_i,
// and the default bus widths used by both sides.
// ---------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } bus_state_e;

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    localparam int DEFAULT_WORD_DATA_WIDTH = 32;
    localparam int DEFAULT_WORD_ADDR_WIDTH = 30;

endpackage

// File: rtl/bus_sram_slave_if.sv
// ---------------------------------------------------------------------------
// bus_sram_slave_if
// Word bus between an initiator (CPU memory stage) and a responder.
//   cs_i, as_i, rw_i, addr_i, wr_data_i : request, driven by the master
//   rd_data_o, rdy_o, err_o            : response, driven by the slave
// ---------------------------------------------------------------------------
interface bus_sram_slave_if
    import bus_pkg::*;
#(
    parameter int WORD_DATA_WIDTH = DEFAULT_WORD_DATA_WIDTH,
    parameter int WORD_ADDR_WIDTH = DEFAULT_WORD_ADDR_WIDTH
);
    logic                       cs_i;
    logic                       as_i;
    logic                       rw_i;
    logic [WORD_ADDR_WIDTH-1:0] addr_i;
    logic [WORD_DATA_WIDTH-1:0] wr_data_i;
    logic [WORD_DATA_WIDTH-1:0] rd_data_o;
    logic                       rdy_o;
    logic                       err_o;

    modport master (
        output cs_i, as_i, rw_i, addr_i, wr_data_i,
        input  rd_data_o, rdy_o, err_o
    );

    modport slave (
        input  cs_i, as_i, rw_i, addr_i, wr_data_i,
        output rd_data_o, rdy_o, err_o
    );
endinterface

// File: rtl/bus_sram_slave_sram_array.sv
// ---------------------------------------------------------------------------
// sram_array
// DEPTH x WORD_DATA_WIDTH word storage.
//   clk      : write clock
//   we_i     : write enable, data stored at the rising edge
//   idx_i    : word index for both write and read
//   wr_data_i: write data
//   rd_data_o: combinational read of the word at idx_i
// Contents are never reset.
// ---------------------------------------------------------------------------
module sram_array #(
    parameter int DEPTH           = 1024,
    parameter int WORD_DATA_WIDTH = 32,
    parameter int IDX_W           = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [IDX_W-1:0]           idx_i,
    input  logic [WORD_DATA_WIDTH-1:0] wr_data_i,
    output logic [WORD_DATA_WIDTH-1:0] rd_data_o
);
    logic [WORD_DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[idx_i];
endmodule

// File: rtl/bus_sram_slave.sv
// ---------------------------------------------------------------------------
// bus_sram_slave
// Word-bus responder backed by an internal SRAM. A request (cs_i & as_i) is
// latched in IDLE, held for WAIT_CYCLES wait states, then answered in a
// single ACK cycle with rdy_o (and err_o for out-of-range addresses).
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of bus_sram_slave_if
// ---------------------------------------------------------------------------
module bus_sram_slave
    import bus_pkg::*;
#(
    parameter int WORD_DATA_WIDTH = DEFAULT_WORD_DATA_WIDTH,
    parameter int WORD_ADDR_WIDTH = DEFAULT_WORD_ADDR_WIDTH,
    parameter int DEPTH           = 1024,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic               clk,
    input  logic               rst,
    bus_sram_slave_if.slave    bus
);
    localparam int IDX_W = $clog2(DEPTH);
    // Counter load value; unused when there are no wait states.
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    bus_state_e                 state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       rw_q, rw_d;
    logic                       in_range_q, in_range_d;
    logic [WORD_DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic                       req;
    logic                       in_range_in;
    logic                       mem_we;
    logic [WORD_DATA_WIDTH-1:0] mem_rd_data;

    assign req         = bus.cs_i & bus.as_i;
    // Any set bit above the index field means the word is outside the array.
    assign in_range_in = ((bus.addr_i >> IDX_W) == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rw_d       = rw_q;
        in_range_d = in_range_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d      = bus.addr_i[IDX_W-1:0];
                    rw_d       = bus.rw_i;
                    in_range_d = in_range_in;
                    wr_data_d  = bus.wr_data_i;
                    cnt_d      = CNT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    // Initiator withdrew the request: drop it silently.
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            rw_q       <= 1'b0;
            in_range_q <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rw_q       <= rw_d;
            in_range_q <= in_range_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // The write lands on the edge that leaves ACK, so a following read sees it.
    assign mem_we = (state_q == ACK) && (rw_q == BUS_WRITE) && in_range_q;

    sram_array #(
        .DEPTH           (DEPTH),
        .WORD_DATA_WIDTH (WORD_DATA_WIDTH),
        .IDX_W           (IDX_W)
    ) u_sram_array (
        .clk       (clk),
        .we_i      (mem_we),
        .idx_i     (idx_q),
        .wr_data_i (wr_data_q),
        .rd_data_o (mem_rd_data)
    );

    // Read data is zero outside a successful read ACK so several responders
    // can be OR-combined onto one return bus.
    assign bus.rdy_o     = (state_q == ACK);
    assign bus.err_o     = (state_q == ACK) && !in_range_q;
    assign bus.rd_data_o = ((state_q == ACK) && (rw_q == BUS_READ) && in_range_q)
                         ? mem_rd_data : '0;
endmodule

// File: tb/tb_bus_sram_slave.sv
module tb_bus_sram_slave;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;      // 0 = two-wait-state slave, 1 = zero-wait-state slave
    logic        cs, as, rw;
    logic [29:0] addr;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_sram_slave_if bus2 ();
    bus_sram_slave_if bus0 ();

    assign bus2.cs_i      = cs & ~sel;
    assign bus2.as_i      = as;
    assign bus2.rw_i      = rw;
    assign bus2.addr_i    = addr;
    assign bus2.wr_data_i = wdata;
    assign bus0.cs_i      = cs & sel;
    assign bus0.as_i      = as;
    assign bus0.rw_i      = rw;
    assign bus0.addr_i    = addr;
    assign bus0.wr_data_i = wdata;

    logic        obs_rdy, obs_err;
    logic [31:0] obs_rd;
    assign obs_rdy = sel ? bus0.rdy_o     : bus2.rdy_o;
    assign obs_err = sel ? bus0.err_o     : bus2.err_o;
    assign obs_rd  = sel ? bus0.rd_data_o : bus2.rd_data_o;

    bus_sram_slave #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    bus_sram_slave #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge. Issues one request, waits (bounded) for
    // rdy_o and checks latency, err_o and rd_data_o; rd_data_o must be zero in
    // every non-ACK cycle. Returns just after the edge that leaves ACK.
    task automatic req(input logic r, input logic [29:0] a, input logic [31:0] d,
                       input int exp_lat, input logic exp_err, input logic [31:0] exp_rd,
                       input bit hold);
        int k = 0;
        bit seen = 1'b0;
        logic got_err;
        logic [31:0] got_rd;
        got_err = 1'b0;
        got_rd  = 32'h0;
        cs = 1'b1; as = 1'b1; rw = r; addr = a; wdata = d;
        @(posedge clk); #1;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (obs_rdy) begin
                seen    = 1'b1;
                got_err = obs_err;
                got_rd  = obs_rd;
            end else begin
                check_eq("rd_zero_idle", obs_rd, 32'h0);
            end
        end
        check_eq("rdy_seen", 32'(seen), 32'd1);
        check_eq("latency", k, exp_lat);
        check_eq("err", 32'(got_err), 32'(exp_err));
        check_eq("rd_data", got_rd, exp_rd);
        $display("txn dut=%0d %s addr=%h wdata=%h lat=%0d err=%b rd=%h",
                 sel ? 0 : 2, r ? "RD" : "WR", a, d, k, got_err, got_rd);
        @(posedge clk); #1;
        check_eq("rdy_one_cycle", 32'(obs_rdy), 32'd0);
        if (!hold) begin
            cs = 1'b0; as = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; cs = 1'b0; as = 1'b0; rw = 1'b0;
        addr = '0; wdata = '0;
        #1;
        check_eq("reset_rdy", 32'(bus2.rdy_o), 32'd0);
        check_eq("reset_err", 32'(bus2.err_o), 32'd0);
        check_eq("reset_rd", bus2.rd_data_o, 32'h0);
        check_eq("reset_rdy0", 32'(bus0.rdy_o), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Write then read, two wait states.
        req(BUS_WRITE, 30'h5, 32'hDEADBEEF, 3, 1'b0, 32'h0, 1'b0);
        req(BUS_READ,  30'h5, 32'h0,        3, 1'b0, 32'hDEADBEEF, 1'b0);

        // Out-of-range accesses.
        req(BUS_WRITE, 30'h0,   32'hC0FFEE00, 3, 1'b0, 32'h0, 1'b0);
        req(BUS_READ,  30'h400, 32'h0,        3, 1'b1, 32'h0, 1'b0);
        req(BUS_WRITE, 30'h400, 32'h1234,     3, 1'b1, 32'h0, 1'b0);
        req(BUS_READ,  30'h0,   32'h0,        3, 1'b0, 32'hC0FFEE00, 1'b0);

        // Abort during WAIT.
        req(BUS_WRITE, 30'h7, 32'h77770007, 3, 1'b0, 32'h0, 1'b0);
        cs = 1'b1; as = 1'b1; rw = BUS_WRITE; addr = 30'h7; wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        cs = 1'b0; as = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("abort_no_rdy", 32'(obs_rdy), 32'd0);
        end
        $display("txn dut=2 WR addr=%h wdata=%h aborted", 30'h7, 32'hA5A5A5A5);
        @(posedge clk); #1;
        req(BUS_READ, 30'h7, 32'h0, 3, 1'b0, 32'h77770007, 1'b0);

        // Asynchronous reset while waiting.
        req(BUS_WRITE, 30'h2, 32'h00000022, 3, 1'b0, 32'h0, 1'b0);
        cs = 1'b1; as = 1'b1; rw = BUS_WRITE; addr = 30'h2; wdata = 32'hFF;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_rdy", 32'(obs_rdy), 32'd0);
        check_eq("rst_err", 32'(obs_err), 32'd0);
        check_eq("rst_rd", obs_rd, 32'h0);
        check_eq("rst_state", 32'(u_dut2.state_q), 32'(IDLE));
        check_eq("rst_cnt", 32'(u_dut2.cnt_q), 32'd0);
        $display("txn dut=2 WR addr=%h wdata=%h reset mid-wait", 30'h2, 32'hFF);
        @(posedge clk); #1;
        rst = 1'b0; cs = 1'b0; as = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("post_rst_no_rdy", 32'(obs_rdy), 32'd0);
        end
        @(posedge clk); #1;
        req(BUS_READ, 30'h2, 32'h0, 3, 1'b0, 32'h00000022, 1'b0);

        // Strobe without chip select is ignored.
        cs = 1'b0; as = 1'b1; rw = BUS_READ; addr = 30'h5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("nocs_no_rdy", 32'(obs_rdy), 32'd0);
        end
        check_eq("nocs_state", 32'(u_dut2.state_q), 32'(IDLE));
        $display("txn dut=2 RD addr=%h cs low, ignored", 30'h5);
        as = 1'b0;
        @(posedge clk); #1;

        // Back-to-back on the zero-wait-state slave.
        sel = 1'b1;
        @(posedge clk); #1;
        req(BUS_WRITE, 30'h10, 32'h11, 1, 1'b0, 32'h0, 1'b1);
        req(BUS_READ,  30'h10, 32'h0,  1, 1'b0, 32'h11, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
